// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the memory arbiter: the word type, the RAM handshake
// states and the arbiter FSM encoding. Also holds a width helper for the
// anti-starvation counter.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  // Bits needed to hold the values 0..max inclusive (at least one bit).
  function automatic int ctr_width(input int unsigned max);
    if (max < 2) return 1;
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_ctr.sv
// starve_ctr: saturating up-counter of icache stall cycles. inc advances the
// count until it reaches MAX_IWAIT, clr returns it to zero (clr wins), and sat
// reports that the icache has waited long enough to preempt the dcache.
module starve_ctr
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_IWAIT = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam int W = ctr_width(MAX_IWAIT);
  localparam logic [W-1:0] MAXV = W'(MAX_IWAIT);

  logic [W-1:0] cnt;

  // Count stall cycles, holding at the limit until the icache completes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != MAXV)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign sat = (cnt >= MAXV);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: sole master of the single-port RAM, sitting below icache and
// dcache. The dcache has fixed priority; an icache that has stalled MAX_IWAIT
// cycles takes the next grant unless the dcache is in the middle of a two-word
// block (first word at daddr[2]==0), which is never split.
// Grant state is registered; RAM controls and the owner's wait/load are decoded
// combinationally from it so a RAM ACCESS completes the owner in the same cycle.
// Optional feature macro: ARB_STATS_EN adds icount/dcount completion counters;
// without it both outputs are tied to zero.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned MAX_IWAIT = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic [31:0] icount,
  output logic [31:0] dcount
);

  arb_state_t state;
  logic       blk_lock;
  logic       starve_sat;
  logic       dreq;
  logic       ram_acc;
  logic       d_done;
  logic       i_done;

  assign dreq    = dREN | dWEN;
  assign ram_acc = (ramstate_t'(ramstate) == ACCESS);
  assign d_done  = (state == DGRANT) && dreq && ram_acc;
  assign i_done  = (state == IGRANT) && iREN && ram_acc;

  starve_ctr #(
    .MAX_IWAIT(MAX_IWAIT)
  ) u_starve (
    .CLK(CLK),
    .RST(RST),
    .inc(iREN && (state != IGRANT)),
    .clr(i_done),
    .sat(starve_sat)
  );

  // Grant FSM and block lock: choose an owner in IDLE, return to IDLE on
  // completion or when the owner withdraws its request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      blk_lock <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!dreq) blk_lock <= 1'b0;
          if (blk_lock && dreq)        state <= DGRANT;
          else if (starve_sat && iREN) state <= IGRANT;
          else if (dreq)               state <= DGRANT;
          else if (iREN)               state <= IGRANT;
        end
        DGRANT: begin
          if (d_done) begin
            state    <= IDLE;
            blk_lock <= ~daddr[2];
          end else if (!dreq) begin
            state <= IDLE;
          end
        end
        IGRANT: begin
          if (i_done || !iREN) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Route the owner onto the RAM; the non-owner always sees wait=1, load=0.
  always_comb begin
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      DGRANT: begin
        if (dreq) begin
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ramaddr  = daddr;
          ramstore = dstore;
          if (ram_acc) begin
            dwait = 1'b0;
            dload = ramload;
          end
        end
      end
      IGRANT: begin
        if (iREN) begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ram_acc) begin
            iwait = 1'b0;
            iload = ramload;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef ARB_STATS_EN
  // Completed-transaction counters, wrapping naturally at 2^32.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      icount <= '0;
      dcount <= '0;
    end else begin
      if (i_done) icount <= icount + 32'd1;
      if (d_done) dcount <= dcount + 32'd1;
    end
  end
`else
  assign icount = '0;
  assign dcount = '0;
`endif

endmodule
